// File: rtl/mcctrl_if.sv
// Control bundle between the instruction register/ALU and the multi-cycle FSM.
// Carries decode inputs and all datapath control strobes.
interface mcctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic       EXTOp;
  logic [2:0] ALUOp;
  logic [1:0] NPCOp;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic       ALUSrc;
  logic [2:0] state;
  logic       illegal;

  modport master (
    output opcode, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, EXTOp, ALUOp,
    input  NPCOp, RegDst, WDSel, ALUSrc, state, illegal
  );

  modport slave (
    input  opcode, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, EXTOp, ALUOp,
    output NPCOp, RegDst, WDSel, ALUSrc, state, illegal
  );
endinterface

// File: rtl/mcctrl.sv
// Multi-cycle MIPS-subset control FSM (fetch/decode/exec/mem/wb).
// Optional retired-instruction counter: define MCCTRL_RETIRE_CNT_EN.
module mcctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  mcctrl_if.slave     bus
`ifdef MCCTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0] st;
  logic [2:0] nxt;
  logic [3:0] wcnt;
  logic       last;

  logic is_r, is_add, is_sub, is_jr, is_ori, is_lw;
  logic is_sw, is_beq, is_lui, is_j, is_jal, supported;

  assign is_r   = bus.opcode == 6'b000000;
  assign is_add = is_r && bus.funct == 6'b100000;
  assign is_sub = is_r && bus.funct == 6'b100010;
  assign is_jr  = is_r && bus.funct == 6'b001000;
  assign is_ori = bus.opcode == 6'b001101;
  assign is_lw  = bus.opcode == 6'b100011;
  assign is_sw  = bus.opcode == 6'b101011;
  assign is_beq = bus.opcode == 6'b000100;
  assign is_lui = bus.opcode == 6'b001111;
  assign is_j   = bus.opcode == 6'b000010;
  assign is_jal = bus.opcode == 6'b000011;

  assign supported = is_add | is_sub | is_jr | is_ori | is_lw |
                     is_sw | is_beq | is_lui | is_j | is_jal;

  assign last = wcnt == 4'(MEM_WAIT);

  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (supported && !(is_j || is_jr || is_jal))
          nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw)
          nxt = S_MEM;
        else if (is_add || is_sub || is_ori || is_lui)
          nxt = S_WB;
      end
      S_MEM: begin
        if (!last)
          nxt = S_MEM;
        else if (is_lw)
          nxt = S_WB;
      end
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= S_FETCH;
      wcnt <= '0;
    end else begin
      st <= nxt;
      if (st == S_MEM && !last)
        wcnt <= wcnt + 4'd1;
      else
        wcnt <= '0;
    end
  end

  // ALU/extender setup, held from S_EXEC through S_MEM and S_WB
  logic [2:0] alu_op;
  logic       alu_src;
  logic       ext_op;

  always_comb begin
    alu_op  = 3'b000;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    unique case (1'b1)
      is_sub:         alu_op = 3'b001;
      is_ori: begin
        alu_op  = 3'b010;
        alu_src = 1'b1;
      end
      is_lui: begin
        alu_op  = 3'b011;
        alu_src = 1'b1;
      end
      is_lw, is_sw: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      is_beq: begin
        alu_op = 3'b001;
        ext_op = 1'b1;
      end
      default: ;
    endcase
  end

  logic       pc_wr, ir_wr, reg_wr, mem_wr, ill;
  logic       ext_o, src_o;
  logic [2:0] aop_o;
  logic [1:0] npc_o, dst_o, wd_o;

  always_comb begin
    pc_wr  = 1'b0;
    ir_wr  = 1'b0;
    reg_wr = 1'b0;
    mem_wr = 1'b0;
    ill    = 1'b0;
    ext_o  = 1'b0;
    src_o  = 1'b0;
    aop_o  = 3'b000;
    npc_o  = 2'b00;
    dst_o  = 2'b00;
    wd_o   = 2'b00;
    case (st)
      S_FETCH: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_wr = 1'b1;
          npc_o = 2'b10;
        end
        if (is_jr) begin
          pc_wr = 1'b1;
          npc_o = 2'b11;
        end
        if (is_jal) begin
          reg_wr = 1'b1;
          dst_o  = 2'b10;
          wd_o   = 2'b10;
        end
        ill = !supported;
      end
      S_EXEC: begin
        aop_o = alu_op;
        src_o = alu_src;
        ext_o = ext_op;
        if (is_beq) begin
          npc_o = 2'b01;
          pc_wr = bus.zero;
        end
      end
      S_MEM: begin
        aop_o  = alu_op;
        src_o  = alu_src;
        ext_o  = ext_op;
        mem_wr = is_sw && last;
      end
      S_WB: begin
        aop_o  = alu_op;
        src_o  = alu_src;
        ext_o  = ext_op;
        reg_wr = 1'b1;
        dst_o  = is_r ? 2'b01 : 2'b00;
        wd_o   = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // Reset gates strobes combinationally so an abort never writes
  assign bus.PCWr    = reset & pc_wr;
  assign bus.IRWr    = reset & ir_wr;
  assign bus.RegWr   = reset & reg_wr;
  assign bus.MemWr   = reset & mem_wr;
  assign bus.illegal = reset & ill;
  assign bus.EXTOp   = ext_o;
  assign bus.ALUSrc  = src_o;
  assign bus.ALUOp   = aop_o;
  assign bus.NPCOp   = npc_o;
  assign bus.RegDst  = dst_o;
  assign bus.WDSel   = wd_o;
  assign bus.state   = st;

`ifdef MCCTRL_RETIRE_CNT_EN
  logic retire;

  assign retire = nxt == S_FETCH &&
                  ((st == S_DECODE && supported) ||
                   st == S_EXEC || st == S_MEM || st == S_WB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instr_cnt <= '0;
    else if (retire)
      instr_cnt <= instr_cnt + 32'd1;
  end
`endif

endmodule
